// File: rtl/conv_pkg.sv
// Shared FSM encoding and elaboration helpers for the convolution MAC engine.
package conv_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_MAC,
      ST_FIN,
      ST_DONE
   } conv_state_e;

   function automatic int clog2(input int value);
      int result;
      int v;
      result = 0;
      v      = value - 1;
      while (v > 0) begin
         result++;
         v = v >> 1;
      end
      return result;
   endfunction

   // Counter/index width that never collapses to zero bits.
   function automatic int cnt_width(input int value);
      return (clog2(value) < 1) ? 1 : clog2(value);
   endfunction

   function automatic int calc_n(input int in_channels, input int kernel_size);
      return in_channels * kernel_size * kernel_size;
   endfunction

   function automatic int calc_acc_width(input int data_width, input int n);
      return 2 * data_width + clog2(n) + 1;
   endfunction

   function automatic longint sat_hi(input int data_width);
      return (longint'(1) <<< (data_width - 1)) - 1;
   endfunction

   function automatic longint sat_lo(input int data_width);
      return -(longint'(1) <<< (data_width - 1));
   endfunction

endpackage

// File: rtl/conv_requant.sv
// Combinational requantiser: bias add, round half-up, arithmetic shift, saturate.
// Fused ReLU on the saturated result when CONV_RELU_EN is defined.
module conv_requant
   import conv_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int FRAC_BITS  = 8,
   parameter int ACC_WIDTH  = 40
) (
   input  logic signed [ACC_WIDTH-1:0]  acc_in,
   input  logic signed [DATA_WIDTH-1:0] bias_in,
   output logic signed [DATA_WIDTH-1:0] result_out
);

   localparam int RND_SHIFT = (FRAC_BITS > 0) ? FRAC_BITS - 1 : 0;
   localparam logic signed [ACC_WIDTH-1:0] ROUND_C =
      (FRAC_BITS > 0) ? ACC_WIDTH'(64'sd1 <<< RND_SHIFT) : '0;
   localparam logic signed [ACC_WIDTH-1:0] SAT_HI = ACC_WIDTH'(sat_hi(DATA_WIDTH));
   localparam logic signed [ACC_WIDTH-1:0] SAT_LO = ACC_WIDTH'(sat_lo(DATA_WIDTH));

   logic signed [ACC_WIDTH-1:0]  sum;
   logic signed [ACC_WIDTH-1:0]  shifted;
   logic signed [DATA_WIDTH-1:0] sat;

   // NOTE: combinational logic uses blocking '=' so each line sees the value computed just above it.
   always_comb begin
      sum     = acc_in + (ACC_WIDTH'(bias_in) <<< FRAC_BITS) + ROUND_C;
      shifted = sum >>> FRAC_BITS;
      if (shifted > SAT_HI) begin
         sat = SAT_HI[DATA_WIDTH-1:0];
      end else if (shifted < SAT_LO) begin
         sat = SAT_LO[DATA_WIDTH-1:0];
      end else begin
         sat = shifted[DATA_WIDTH-1:0];
      end
`ifdef CONV_RELU_EN
      result_out = sat[DATA_WIDTH-1] ? '0 : sat;
`else
      result_out = sat;
`endif
   end

endmodule

// File: rtl/conv_mac_engine.sv
// Time-multiplexed single-MAC convolution engine with loadable weight/bias RAM.
// Define CONV_RELU_EN to fuse a ReLU after saturation (handled in conv_requant).
module conv_mac_engine
   import conv_pkg::*;
#(
   parameter int IN_CHANNELS       = 12,
   parameter int OUT_CHANNELS      = 12,
   parameter int KERNEL_SIZE       = 3,
   parameter int DATA_WIDTH        = 16,
   parameter int FRAC_BITS         = 8,
   parameter int WEIGHT_ADDR_WIDTH = 20
) (
   input  logic                                                       clk,
   input  logic                                                       rst,
   input  logic                                                       load_weights,
   input  logic [WEIGHT_ADDR_WIDTH-1:0]                               weight_addr,
   input  logic [DATA_WIDTH-1:0]                                      weight_in,
   output logic                                                       load_err,
   input  logic                                                       start_conv,
   input  logic [IN_CHANNELS*KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0]  pixel_in,
   output logic                                                       busy,
   output logic                                                       conv_done,
   output logic [OUT_CHANNELS*DATA_WIDTH-1:0]                         pixel_out
);

   localparam int N         = calc_n(IN_CHANNELS, KERNEL_SIZE);
   localparam int ACC_W     = calc_acc_width(DATA_WIDTH, N);
   localparam int PW        = 2 * DATA_WIDTH;
   localparam int DEPTH     = OUT_CHANNELS * (N + 1);
   localparam int BIAS_BASE = OUT_CHANNELS * N;
   localparam int MEM_AW    = cnt_width(DEPTH);
   localparam int EW        = cnt_width(N);
   localparam int OW        = cnt_width(OUT_CHANNELS);

   conv_state_e                  state_q, state_d;
   logic [EW-1:0]                e_q, e_d, mul_idx;
   logic [OW-1:0]                o_q, o_d;
   logic signed [ACC_W-1:0]      acc_q, acc_d, acc_sum;
   logic signed [DATA_WIDTH-1:0] win_q [N];
   logic signed [DATA_WIDTH-1:0] win_d [N];
   logic signed [DATA_WIDTH-1:0] pix_q [OUT_CHANNELS];
   logic signed [DATA_WIDTH-1:0] pix_d [OUT_CHANNELS];
   logic                         busy_q, busy_d, done_q, done_d, err_q, err_d;
   logic signed [DATA_WIDTH-1:0] mem [DEPTH];
   logic signed [DATA_WIDTH-1:0] rd_w_q, rd_b_q;
   logic [MEM_AW-1:0]            rd_w_addr, rd_b_addr;
   logic signed [DATA_WIDTH-1:0] mul_pix, result;
   logic signed [PW-1:0]         prod;
   logic                         wr_ok, start_ok;

   assign wr_ok    = load_weights && !rst && !busy_q &&
                     (weight_addr < WEIGHT_ADDR_WIDTH'(DEPTH));
   assign start_ok = start_conv && !busy_q && (state_q == ST_IDLE);

   // Product for the element whose RAM read landed this cycle (one cycle behind the issue index).
   always_comb begin
      mul_idx   = (state_q == ST_FIN) ? EW'(N - 1) : ((e_q == '0) ? '0 : e_q - 1'b1);
      mul_pix   = win_q[mul_idx];
      prod      = PW'(rd_w_q) * PW'(mul_pix);
      acc_sum   = acc_q + ACC_W'(prod);
      rd_w_addr = MEM_AW'(int'(o_q) * N + int'(e_q));
      rd_b_addr = MEM_AW'(BIAS_BASE + int'(o_q));
   end

   conv_requant #(
      .DATA_WIDTH (DATA_WIDTH),
      .FRAC_BITS  (FRAC_BITS),
      .ACC_WIDTH  (ACC_W)
   ) u_requant (
      .acc_in     (acc_sum),
      .bias_in    (rd_b_q),
      .result_out (result)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (start_ok) state_d = ST_MAC;
         ST_MAC:  if (e_q == EW'(N - 1)) state_d = ST_FIN;
         ST_FIN:  state_d = (o_q == OW'(OUT_CHANNELS - 1)) ? ST_DONE : ST_MAC;
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // NOTE: every signal gets a default before the case, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      e_d    = e_q;
      o_d    = o_q;
      acc_d  = acc_q;
      win_d  = win_q;
      pix_d  = pix_q;
      busy_d = busy_q;
      done_d = (state_q == ST_DONE);
      err_d  = load_weights && !wr_ok;
      case (state_q)
         ST_IDLE: begin
            if (start_ok) begin
               for (int i = 0; i < N; i++) begin
                  win_d[i] = pixel_in[i*DATA_WIDTH +: DATA_WIDTH];
               end
               acc_d  = '0;
               e_d    = '0;
               o_d    = '0;
               busy_d = 1'b1;
            end else if (done_q) begin
               busy_d = 1'b0;
            end
         end
         ST_MAC: begin
            if (e_q != '0) acc_d = acc_sum;
            e_d = (e_q == EW'(N - 1)) ? '0 : e_q + 1'b1;
         end
         ST_FIN: begin
            pix_d[o_q] = result;
            acc_d      = '0;
            if (o_q != OW'(OUT_CHANNELS - 1)) o_d = o_q + 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         e_q    <= '0;
         o_q    <= '0;
         acc_q  <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
         err_q  <= 1'b0;
         for (int i = 0; i < OUT_CHANNELS; i++) pix_q[i] <= '0;
      end else begin
         e_q    <= e_d;
         o_q    <= o_d;
         acc_q  <= acc_d;
         busy_q <= busy_d;
         done_q <= done_d;
         err_q  <= err_d;
         pix_q  <= pix_d;
      end
   end

   always_ff @(posedge clk) begin
      win_q <= win_d;
   end

   // NOTE: the weight RAM is deliberately not reset so it maps onto block RAM; contents are undefined until loaded.
   always_ff @(posedge clk) begin
      if (wr_ok) mem[weight_addr[MEM_AW-1:0]] <= weight_in;
      rd_w_q <= mem[rd_w_addr];
      rd_b_q <= mem[rd_b_addr];
   end

   for (genvar g = 0; g < OUT_CHANNELS; g++) begin : g_pack
      assign pixel_out[g*DATA_WIDTH +: DATA_WIDTH] = pix_q[g];
   end

   assign busy      = busy_q;
   assign conv_done = done_q;
   assign load_err  = err_q;

endmodule

// File: tb/tb_conv_mac_engine.sv
// Self-checking bench for conv_mac_engine: directed cases plus randomized runs
// compared every cycle against a behavioural model of the engine.
module tb_conv_mac_engine;

   localparam int IN_CH  = 1;
   localparam int OUT_CH = 2;
   localparam int K      = 3;
   localparam int DW     = 16;
   localparam int FRAC   = 8;
   localparam int WAW    = 20;
   localparam int N      = IN_CH * K * K;
   localparam int DEPTH  = OUT_CH * (N + 1);
   localparam int LAT    = OUT_CH * (N + 1) + 1;

   logic               clk = 1'b0;
   logic               rst;
   logic               load_weights;
   logic [WAW-1:0]     weight_addr;
   logic [DW-1:0]      weight_in;
   logic               load_err;
   logic               start_conv;
   logic [N*DW-1:0]    pixel_in;
   logic               busy;
   logic               conv_done;
   logic [OUT_CH*DW-1:0] pixel_out;

   int n_pass   = 0;
   int n_checks = 0;

   conv_mac_engine #(
      .IN_CHANNELS       (IN_CH),
      .OUT_CHANNELS      (OUT_CH),
      .KERNEL_SIZE       (K),
      .DATA_WIDTH        (DW),
      .FRAC_BITS         (FRAC),
      .WEIGHT_ADDR_WIDTH (WAW)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .load_weights (load_weights),
      .weight_addr  (weight_addr),
      .weight_in    (weight_in),
      .load_err     (load_err),
      .start_conv   (start_conv),
      .pixel_in     (pixel_in),
      .busy         (busy),
      .conv_done    (conv_done),
      .pixel_out    (pixel_out)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic signed [DW-1:0]  wmem [DEPTH];
   logic [N*DW-1:0]       m_win;
   int                    cyc = 0;
   int                    m_ts = 0;
   logic                  m_busy = 1'b0;
   logic                  m_active = 1'b0;
   logic                  exp_done = 1'b0;
   logic                  exp_err = 1'b0;
   logic [OUT_CH*DW-1:0]  exp_pix = '0;

   initial for (int i = 0; i < DEPTH; i++) wmem[i] = '0;

   function automatic logic [OUT_CH*DW-1:0] model_out();
      logic [OUT_CH*DW-1:0] r;
      r = '0;
      for (int o = 0; o < OUT_CH; o++) begin
         longint s;
         s = 0;
         for (int e = 0; e < N; e++) begin
            logic signed [DW-1:0] px;
            px = m_win[e*DW +: DW];
            s += longint'(wmem[o*N + e]) * longint'(px);
         end
         s += longint'(wmem[OUT_CH*N + o]) * (longint'(1) <<< FRAC);
         s += longint'(1) <<< (FRAC - 1);
         s = s >>> FRAC;
         if (s > 32767) s = 32767;
         else if (s < -32768) s = -32768;
`ifdef CONV_RELU_EN
         if (s < 0) s = 0;
`endif
         r[o*DW +: DW] = s[15:0];
      end
      return r;
   endfunction

   always @(posedge clk) begin
      logic prev_busy;
      cyc++;
      if (rst) begin
         m_busy   = 1'b0;
         m_active = 1'b0;
         exp_done = 1'b0;
         exp_err  = 1'b0;
         exp_pix  = '0;
      end else begin
         prev_busy = m_busy;
         exp_err   = load_weights && (prev_busy || (int'(weight_addr) >= DEPTH));
         if (load_weights && !exp_err) wmem[int'(weight_addr)] = weight_in;
         exp_done = m_active && (cyc == m_ts + LAT);
         if (exp_done) exp_pix = model_out();
         if (start_conv && !prev_busy) begin
            m_active = 1'b1;
            m_ts     = cyc;
            m_win    = pixel_in;
         end
         m_busy = m_active && (cyc <= m_ts + LAT);
         if (!m_busy) m_active = 1'b0;
      end
   end

   // Single compare process: handshake every cycle, result whenever it is defined.
   always @(negedge clk) begin
      if (cyc > 0) begin
         check("busy", 64'(busy), 64'(m_busy));
         check("conv_done", 64'(conv_done), 64'(exp_done));
         check("load_err", 64'(load_err), 64'(exp_err));
         if (!m_busy || exp_done) check("pixel_out", 64'(pixel_out), 64'(exp_pix));
      end
   end

   // ---------------- stimulus helpers (called right after a negedge) ----------------
   task automatic wr(input int a, input logic [DW-1:0] d);
      load_weights = 1'b1;
      weight_addr  = WAW'(a);
      weight_in    = d;
      @(negedge clk);
      load_weights = 1'b0;
   endtask

   task automatic load_cfg(input logic [DW-1:0] w, input logic [DW-1:0] b0, input logic [DW-1:0] b1);
      for (int a = 0; a < OUT_CH * N; a++) wr(a, w);
      wr(OUT_CH * N, b0);
      wr(OUT_CH * N + 1, b1);
   endtask

   task automatic set_pix(input logic [DW-1:0] p);
      for (int e = 0; e < N; e++) pixel_in[e*DW +: DW] = p;
   endtask

   task automatic wait_done(input string name);
      int lat;
      lat = -1;
      for (int i = 0; i < 100 && !conv_done; i++) @(negedge clk);
      if (conv_done) lat = cyc - m_ts;
      check(name, 64'(lat), 64'(LAT));
   endtask

   task automatic run(input string name);
      start_conv = 1'b1;
      @(negedge clk);
      start_conv = 1'b0;
      wait_done(name);
   endtask

   task automatic settle();
      repeat (2) @(negedge clk);
   endtask

   function automatic logic [DW-1:0] rnd_val(input logic full);
      if (full) return DW'($urandom);
      return DW'($urandom_range(0, 1023)) - DW'(512);
   endfunction

   initial begin
      rst          = 1'b1;
      load_weights = 1'b0;
      start_conv   = 1'b0;
      weight_addr  = '0;
      weight_in    = '0;
      pixel_in     = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      check("reset_busy", 64'(busy), 64'(0));
      check("reset_pixel_out", 64'(pixel_out), 64'(0));

      // Unity weights and pixels, half-LSB bias on channel 1.
      load_cfg(16'h0100, 16'h0000, 16'h0080);
      set_pix(16'h0100);
      run("t1_latency");
      check("t1_result", 64'(pixel_out), 64'h0980_0900);
      settle();

      // Saturation both ways.
      load_cfg(16'h7FFF, 16'h0000, 16'h0000);
      set_pix(16'h7FFF);
      run("t2_pos_latency");
      check("t2_pos_sat", 64'(pixel_out), 64'h7FFF_7FFF);
      settle();
      set_pix(16'h8000);
      run("t2_neg_latency");
`ifdef CONV_RELU_EN
      check("t2_neg_sat", 64'(pixel_out), 64'h0000_0000);
`else
      check("t2_neg_sat", 64'(pixel_out), 64'h8000_8000);
`endif
      settle();

      // Round half-up on a single half-LSB product.
      load_cfg(16'h0000, 16'h0000, 16'h0000);
      wr(0, 16'h0080);
      wr(N, 16'h0080);
      set_pix(16'h0000);
      pixel_in[0 +: DW] = 16'h0001;
      run("t3_up_latency");
      check("t3_round_up", 64'(pixel_out), 64'h0001_0001);
      settle();
      pixel_in[0 +: DW] = 16'hFFFF;
      run("t3_neg_latency");
      check("t3_round_neg", 64'(pixel_out), 64'h0000_0000);
      settle();

      // Negative result, with and without ReLU.
      load_cfg(16'h0100, 16'h0000, 16'h0000);
      set_pix(16'hFF00);
      run("t4_latency");
`ifdef CONV_RELU_EN
      check("t4_negative", 64'(pixel_out), 64'h0000_0000);
`else
      check("t4_negative", 64'(pixel_out), 64'hF700_F700);
`endif
      settle();

      // Out-of-range writes are rejected, in-range accepted.
      wr(DEPTH, 16'h5555);
      check("oor_err_first", 64'(load_err), 64'(1));
      wr(int'(20'hFFFFF), 16'h5555);
      check("oor_err_max", 64'(load_err), 64'(1));
      wr(DEPTH - 1, 16'h0080);
      check("in_range_no_err", 64'(load_err), 64'(0));

      // Start and write while busy are ignored; RAM keeps its contents.
      set_pix(16'h0100);
      start_conv = 1'b1;
      @(negedge clk);
      start_conv = 1'b0;
      repeat (3) @(negedge clk);
      start_conv = 1'b1;
      wr(3, 16'h1234);
      start_conv = 1'b0;
      check("t5_busy_err", 64'(load_err), 64'(1));
      wait_done("t5_latency");
      check("t5_result", 64'(pixel_out), 64'h0980_0900);
      settle();
      run("t5_rerun_latency");
      check("t5_ram_unchanged", 64'(pixel_out), 64'h0980_0900);
      settle();

      // Write and start in the same idle cycle: the run sees the new bias.
      load_weights = 1'b1;
      weight_addr  = WAW'(OUT_CH * N);
      weight_in    = 16'h0100;
      start_conv   = 1'b1;
      @(negedge clk);
      load_weights = 1'b0;
      start_conv   = 1'b0;
      wait_done("same_cycle_latency");
      check("same_cycle_result", 64'(pixel_out), 64'h0980_0A00);
      settle();

      // Reset mid-MAC aborts the run; the next run completes normally.
      start_conv = 1'b1;
      @(negedge clk);
      start_conv = 1'b0;
      repeat (5) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("t6_busy", 64'(busy), 64'(0));
      check("t6_pixel_out", 64'(pixel_out), 64'(0));
      check("t6_no_done", 64'(conv_done), 64'(0));
      repeat (30) @(negedge clk);
      run("t6_latency");
      check("t6_result", 64'(pixel_out), 64'h0980_0A00);
      settle();

      // Randomized runs: small values exercise exact arithmetic, full range exercises saturation.
      for (int r = 0; r < 16; r++) begin
         logic full;
         full = (r % 4 == 3);
         for (int a = 0; a < DEPTH; a++) wr(a, rnd_val(full));
         for (int e = 0; e < N; e++) pixel_in[e*DW +: DW] = rnd_val(full);
         run("rand_latency");
         settle();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation did not finish, got %0d checks", n_checks);
      $fatal(1, "timeout");
   end

endmodule
